// File: rtl/systolic_feeder_if.sv
// Weight-row and input-vector handshakes between the unified buffer read port and the feeder.
// master = producer of rows/vectors, slave = systolic_feeder.
interface systolic_feeder_if #(
  parameter int unsigned SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int unsigned DATA_WIDTH_IN        = 8
);
  localparam int unsigned W  = SYSTOLIC_ARRAY_WIDTH;
  localparam int unsigned DW = DATA_WIDTH_IN;

  logic                 w_valid_in;
  logic                 w_ready_out;
  logic [W-1:0][DW-1:0] w_row_in;
  logic                 x_valid_in;
  logic                 x_ready_out;
  logic [W-1:0][DW-1:0] x_vec_in;
  logic                 x_last_in;

  modport master (
    output w_valid_in, w_row_in, x_valid_in, x_vec_in, x_last_in,
    input  w_ready_out, x_ready_out
  );

  modport slave (
    input  w_valid_in, w_row_in, x_valid_in, x_vec_in, x_last_in,
    output w_ready_out, x_ready_out
  );
endinterface

// File: rtl/systolic_feeder.sv
// Drives a WxW systolic array: row-tagged weight tile on the A-flow, then skewed input vectors
// on the B-flow. Optional macro SYSTOLIC_FEEDER_ZERO_GATE_EN zeroes unqualified data/weights.
module systolic_feeder #(
  parameter int unsigned SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int unsigned DATA_WIDTH_IN        = 8,
  localparam int unsigned W  = SYSTOLIC_ARRAY_WIDTH,
  localparam int unsigned DW = DATA_WIDTH_IN,
  localparam int unsigned IW = $clog2(W),
  localparam int unsigned CW = $clog2(W + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start_in,
  input  logic [CW-1:0]        cfg_col_size_in,
  output logic                 busy_out,
  output logic                 done_out,
  systolic_feeder_if.slave     in_if,
  output logic [W-1:0][DW-1:0] sys_weight_out,
  output logic [W-1:0][IW-1:0] sys_index_out,
  output logic [W-1:0]         sys_accept_w_out,
  output logic [W-1:0][DW-1:0] sys_data_out,
  output logic [W-1:0]         sys_valid_out,
  output logic [W-1:0]         sys_switch_out,
  output logic [CW-1:0]        sys_col_size_out,
  output logic                 sys_col_size_valid_out
);

  typedef enum logic [2:0] {
    StIdle, StLoadW, StDrainW, StSwitch, StStream, StFlush
  } state_e;

  localparam logic [IW-1:0] CntMax = IW'(W - 1);

  state_e               state_q, state_d;
  logic [IW-1:0]        cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 col_valid_q, col_valid_d;
  logic [CW-1:0]        col_size_q, col_size_d;
  logic                 cnt_last;
  logic                 w_xfer;
  logic                 x_xfer;
  logic                 inj_switch;

  logic [W-1:0][DW-1:0] weight_q;
  logic [W-1:0][IW-1:0] index_q;
  logic                 accept_q;

  assign in_if.w_ready_out = (state_q == StLoadW);
  assign in_if.x_ready_out = (state_q == StStream);
  assign w_xfer            = in_if.w_valid_in & in_if.w_ready_out;
  assign x_xfer            = in_if.x_valid_in & in_if.x_ready_out;
  assign cnt_last          = (cnt_q == CntMax);
  assign inj_switch        = (state_q == StSwitch);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    col_valid_d = 1'b0;
    col_size_d  = col_size_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_start_in) begin
          state_d     = StLoadW;
          cnt_d       = '0;
          col_valid_d = 1'b1;
          col_size_d  = (cfg_col_size_in > CW'(W)) ? CW'(W) : cfg_col_size_in;
        end
      end
      StLoadW: begin
        if (w_xfer) begin
          cnt_d = cnt_q + IW'(1);
          if (cnt_last) begin
            state_d = StDrainW;
            cnt_d   = '0;
          end
        end
      end
      StDrainW: begin
        // W idle cycles let the row W-1 weight settle before switch reaches that row.
        cnt_d = cnt_q + IW'(1);
        if (cnt_last) begin
          state_d = StSwitch;
          cnt_d   = '0;
        end
      end
      StSwitch: state_d = StStream;
      StStream: begin
        if (x_xfer && in_if.x_last_in) begin
          state_d = StFlush;
          cnt_d   = '0;
        end
      end
      StFlush: begin
        cnt_d = cnt_q + IW'(1);
        if (cnt_last) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      col_valid_q <= 1'b0;
      col_size_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      col_valid_q <= col_valid_d;
      col_size_q  <= col_size_d;
    end
  end

  // Weights go to every column in the same cycle; only accept_w marks a fresh word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_q <= '0;
      index_q  <= '0;
      accept_q <= 1'b0;
    end else begin
      accept_q <= w_xfer;
      if (w_xfer) begin
        weight_q <= in_if.w_row_in;
        index_q  <= {W{cnt_q}};
      end
    end
  end

  assign sys_index_out    = index_q;
  assign sys_accept_w_out = {W{accept_q}};
`ifdef SYSTOLIC_FEEDER_ZERO_GATE_EN
  assign sys_weight_out   = accept_q ? weight_q : '0;
`else
  assign sys_weight_out   = weight_q;
`endif

  // Row i sits behind i+1 registers; stage 0 data only reloads on a transfer so bubbles hold it.
  for (genvar i = 0; i < W; i++) begin : g_row
    localparam int unsigned Depth = i + 1;
    logic [Depth-1:0] valid_q;
    logic [Depth-1:0] switch_q;
    logic [DW-1:0]    data_q [Depth];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q  <= '0;
        switch_q <= '0;
        for (int s = 0; s < Depth; s++) data_q[s] <= '0;
      end else begin
        valid_q[0]  <= x_xfer;
        switch_q[0] <= inj_switch;
        if (x_xfer) data_q[0] <= in_if.x_vec_in[i];
        for (int s = 1; s < Depth; s++) begin
          valid_q[s]  <= valid_q[s-1];
          switch_q[s] <= switch_q[s-1];
          data_q[s]   <= data_q[s-1];
        end
      end
    end

    assign sys_valid_out[i]  = valid_q[Depth-1];
    assign sys_switch_out[i] = switch_q[Depth-1];
`ifdef SYSTOLIC_FEEDER_ZERO_GATE_EN
    assign sys_data_out[i]   = valid_q[Depth-1] ? data_q[Depth-1] : '0;
`else
    assign sys_data_out[i]   = data_q[Depth-1];
`endif
  end

  assign busy_out               = (state_q != StIdle);
  assign done_out               = done_q;
  assign sys_col_size_out       = col_size_q;
  assign sys_col_size_valid_out = col_valid_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized bench for systolic_feeder against a cycle-history reference model of the tile
// sequence (phase durations plus per-row injection history delayed by row index).
module tb_systolic_feeder;
  localparam int W  = 16;
  localparam int DW = 8;
  localparam int IW = 4;
  localparam int CW = 5;
  localparam int HD = 64;
  localparam int TileLimit = 3000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic                 cfg_start;
  logic [CW-1:0]        cfg_col;
  logic                 busy, done;
  logic [W-1:0][DW-1:0] sys_weight, sys_data;
  logic [W-1:0][IW-1:0] sys_index;
  logic [W-1:0]         sys_acc, sys_valid, sys_switch;
  logic [CW-1:0]        sys_col;
  logic                 sys_colv;

  systolic_feeder_if #(.SYSTOLIC_ARRAY_WIDTH(W), .DATA_WIDTH_IN(DW)) bus ();

  systolic_feeder #(.SYSTOLIC_ARRAY_WIDTH(W), .DATA_WIDTH_IN(DW)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .cfg_start_in          (cfg_start),
    .cfg_col_size_in       (cfg_col),
    .busy_out              (busy),
    .done_out              (done),
    .in_if                 (bus),
    .sys_weight_out        (sys_weight),
    .sys_index_out         (sys_index),
    .sys_accept_w_out      (sys_acc),
    .sys_data_out          (sys_data),
    .sys_valid_out         (sys_valid),
    .sys_switch_out        (sys_switch),
    .sys_col_size_out      (sys_col),
    .sys_col_size_valid_out(sys_colv)
  );

  typedef enum int {PhIdle, PhLoad, PhDrain, PhSwitch, PhStream, PhFlush} phase_e;

  phase_e               ph;
  int                   ph_cnt;
  bit                   m_done, m_colv, m_acc;
  int                   m_col, m_k;
  logic [W-1:0][DW-1:0] m_wt, m_last;
  bit                   h_v [HD][W];
  bit                   h_s [HD][W];
  logic [DW-1:0]        h_d [HD][W];
  int                   cyc;
  int                   n_checks, n_pass;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    ph = PhIdle; ph_cnt = 0; m_done = 0; m_colv = 0; m_acc = 0;
    m_col = 0; m_k = 0; m_wt = '0; m_last = '0;
    for (int h = 0; h < HD; h++)
      for (int i = 0; i < W; i++) begin
        h_v[h][i] = 0; h_s[h][i] = 0; h_d[h][i] = '0;
      end
  endtask

  task automatic check_outputs();
    logic [W-1:0]         ev, es;
    logic [W-1:0][DW-1:0] ed, ew;
    logic [W-1:0][IW-1:0] ei;
    for (int i = 0; i < W; i++) begin
      int h;
      h = (cyc - 1 - i) % HD;
      ev[i] = h_v[h][i];
      es[i] = h_s[h][i];
      ed[i] = h_d[h][i];
`ifdef SYSTOLIC_FEEDER_ZERO_GATE_EN
      if (!ev[i]) ed[i] = '0;
`endif
      ei[i] = IW'(m_k);
    end
    ew = m_wt;
`ifdef SYSTOLIC_FEEDER_ZERO_GATE_EN
    if (!m_acc) ew = '0;
`endif
    check_eq("busy",     128'(busy),             128'(ph != PhIdle));
    check_eq("done",     128'(done),             128'(m_done));
    check_eq("w_ready",  128'(bus.w_ready_out),  128'(ph == PhLoad));
    check_eq("x_ready",  128'(bus.x_ready_out),  128'(ph == PhStream));
    check_eq("col_size", 128'(sys_col),          128'(m_col));
    check_eq("col_vld",  128'(sys_colv),         128'(m_colv));
    check_eq("accept_w", 128'(sys_acc),          128'({W{m_acc}}));
    check_eq("weight",   128'(sys_weight),       128'(ew));
    check_eq("index",    128'(sys_index),        128'(ei));
    check_eq("valid",    128'(sys_valid),        128'(ev));
    check_eq("switch",   128'(sys_switch),       128'(es));
    check_eq("data",     128'(sys_data),         128'(ed));
  endtask

  // Advance the reference by one clock using the inputs presented in this cycle.
  task automatic model_step();
    logic [W-1:0]         iv, is;
    logic [W-1:0][DW-1:0] id;
    iv = '0; is = '0; id = m_last;
    m_acc = 0; m_colv = 0; m_done = 0;
    case (ph)
      PhIdle: if (cfg_start) begin
        m_col = (int'(cfg_col) > W) ? W : int'(cfg_col);
        m_colv = 1; ph = PhLoad; ph_cnt = 0;
      end
      PhLoad: if (bus.w_valid_in) begin
        m_wt = bus.w_row_in; m_k = ph_cnt; m_acc = 1; ph_cnt++;
        if (ph_cnt == W) begin ph = PhDrain; ph_cnt = 0; end
      end
      PhDrain: begin
        ph_cnt++;
        if (ph_cnt == W) ph = PhSwitch;
      end
      PhSwitch: begin is = '1; ph = PhStream; end
      PhStream: if (bus.x_valid_in) begin
        iv = '1; id = bus.x_vec_in; m_last = id;
        if (bus.x_last_in) begin ph = PhFlush; ph_cnt = 0; end
      end
      PhFlush: begin
        ph_cnt++;
        if (ph_cnt == W) begin ph = PhIdle; m_done = 1; end
      end
      default: ph = PhIdle;
    endcase
    for (int i = 0; i < W; i++) begin
      h_v[cyc % HD][i] = iv[i]; h_s[cyc % HD][i] = is[i]; h_d[cyc % HD][i] = id[i];
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    cfg_start = 0; cfg_col = '0;
    bus.w_valid_in = 0; bus.w_row_in = '0;
    bus.x_valid_in = 0; bus.x_vec_in = '0; bus.x_last_in = 0;
  endtask

  task automatic zero_checks(input string tag);
    check_eq({tag, "_busy"},   128'(busy),            128'(0));
    check_eq({tag, "_done"},   128'(done),            128'(0));
    check_eq({tag, "_xready"}, 128'(bus.x_ready_out), 128'(0));
    check_eq({tag, "_wready"}, 128'(bus.w_ready_out), 128'(0));
    check_eq({tag, "_valid"},  128'(sys_valid),       128'(0));
    check_eq({tag, "_switch"}, 128'(sys_switch),      128'(0));
    check_eq({tag, "_data"},   128'(sys_data),        128'(0));
    check_eq({tag, "_weight"}, 128'(sys_weight),      128'(0));
    check_eq({tag, "_index"},  128'(sys_index),       128'(0));
    check_eq({tag, "_accept"}, 128'(sys_acc),         128'(0));
    check_eq({tag, "_col"},    128'(sys_col),         128'(0));
    check_eq({tag, "_colv"},   128'(sys_colv),        128'(0));
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    idle_inputs();
    rst_n = 0;
    #1;
    zero_checks(tag);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic run_tile(input int col, input bit directed, input int rst_after);
    int guard, nvec, target, stream_cycles;
    guard = 0; nvec = 0; stream_cycles = 0;
    target = directed ? 2 : int'($urandom_range(1, 6));
    cfg_col = CW'(col); cfg_start = 1;
    tick();
    cfg_start = 0;
    if (directed) begin
      check_eq("col_clamp", 128'(sys_col),  128'(W));
      check_eq("col_pulse", 128'(sys_colv), 128'(1));
    end
    while (ph != PhIdle && guard < TileLimit) begin
      guard++;
      // A start while busy must be ignored.
      cfg_start = directed && (ph == PhDrain);
      cfg_col   = CW'(3);
      bus.w_valid_in = (ph == PhLoad && directed) ? 1'b1 : 1'($urandom % 2);
      for (int j = 0; j < W; j++)
        bus.w_row_in[j] = (ph == PhLoad && directed) ? DW'(ph_cnt + 1) : DW'($urandom);
      if (ph == PhStream) begin
        stream_cycles++;
        if (rst_after > 0 && stream_cycles == rst_after) begin
          do_reset("rst_mid");
          return;
        end
        if (directed) begin
          bus.x_valid_in = (stream_cycles != 2);
          bus.x_last_in  = (stream_cycles == 3);
          for (int i = 0; i < W; i++)
            bus.x_vec_in[i] = (stream_cycles == 1) ? DW'(i + 1) : DW'(8'h40 + i);
        end else begin
          bus.x_valid_in = ($urandom % 3) != 0;
          bus.x_last_in  = bus.x_valid_in && (nvec + 1 >= target);
          if (bus.x_valid_in) nvec++;
          for (int i = 0; i < W; i++) bus.x_vec_in[i] = DW'($urandom);
        end
      end else begin
        bus.x_valid_in = 1'($urandom % 2);
        bus.x_last_in  = 1'($urandom % 2);
        for (int i = 0; i < W; i++) bus.x_vec_in[i] = DW'($urandom);
      end
      tick();
    end
    check_eq("tile_in_budget", 128'(guard < TileLimit), 128'(1));
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = HD;
    idle_inputs();
    model_reset();
    #1 rst_n = 0;
    #1 zero_checks("rst");
    @(posedge clk);
    #1 rst_n = 1;
    tick();
    tick();
    run_tile(20, 1, 0);
    run_tile(0, 0, 0);
    for (int t = 0; t < 4; t++) run_tile(int'($urandom_range(0, 20)), 0, 0);
    run_tile(16, 0, 3);
    tick();
    tick();
    run_tile(5, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
